// File: rtl/dds_pkg.sv
// Shared constants, types and BCD helpers for the DDS front-panel frequency entry.
package dds_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned DIGITS_W   = 4 * NUM_DIGITS;
    localparam int unsigned FREQ_W     = 20;

    // Largest legal value of each digit, index 0 is d1 (most significant).
    localparam logic [3:0] DIGIT_MAX [NUM_DIGITS] = '{4'd9, 4'd4, 4'd9, 4'd9, 4'd9, 4'd9};

    // Key indices in event priority order (lowest index wins).
    localparam int unsigned KEY_E    = 0;
    localparam int unsigned KEY_U    = 1;
    localparam int unsigned KEY_D    = 2;
    localparam int unsigned KEY_R    = 3;
    localparam int unsigned KEY_L    = 4;
    localparam int unsigned NUM_KEYS = 5;

    typedef enum logic [1:0] {StIdle, StConv, StDone} commit_st_e;

    // Extract BCD digit idx (0 = d1) from a packed setpoint.
    function automatic logic [3:0] get_digit(input logic [DIGITS_W-1:0] d,
                                             input logic [2:0] idx);
        logic [DIGITS_W-1:0] sh;
        sh = d >> (4 * (int'(NUM_DIGITS) - 1 - int'(idx)));
        return sh[3:0];
    endfunction

    // Replace BCD digit idx (0 = d1) in a packed setpoint.
    function automatic logic [DIGITS_W-1:0] put_digit(input logic [DIGITS_W-1:0] d,
                                                      input logic [2:0] idx,
                                                      input logic [3:0] v);
        int unsigned sh;
        sh = 4 * (NUM_DIGITS - 1 - 32'(idx));
        return (d & ~(DIGITS_W'(4'hF) << sh)) | (DIGITS_W'(v) << sh);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low key debouncer: two-flop synchroniser, saturating low-level counter and
// a one-cycle event on the first synchronised release after a qualified press.
module key_debounce
    import dds_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clkin,
    input  logic rst_n,
    input  logic key_n_i,
    output logic evt_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Counter runs while the key is held, saturates, and clears on release.
    always_comb begin
        cnt_d = cnt_q;
        if (sync_q[1]) begin
            cnt_d = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Synchroniser idles high (key released) and the counter starts empty.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], key_n_i};
            cnt_q  <= cnt_d;
        end
    end

    // Counter still holds the saturated value on the first high cycle only.
    assign evt_o = sync_q[1] && (cnt_q == CntMax);

endmodule

// File: rtl/freq_entry.sv
// Front-panel frequency entry: debounced keys edit a 6-digit BCD setpoint with a cursor,
// and each commit converts the setpoint to a binary frequency word over six cycles.
module freq_entry
    import dds_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic                clkin,
    input  logic                rst_n,
    input  logic                ku,
    input  logic                kd,
    input  logic                kr,
    input  logic                kl,
    input  logic                ke,
    output logic [DIGITS_W-1:0] digits,
    output logic [2:0]          cursor,
    output logic [FREQ_W-1:0]   freq_word,
    output logic                freq_valid,
    output logic                busy
);

    logic [NUM_KEYS-1:0] key_evt;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_e (
        .clkin(clkin), .rst_n(rst_n), .key_n_i(ke), .evt_o(key_evt[KEY_E])
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_u (
        .clkin(clkin), .rst_n(rst_n), .key_n_i(ku), .evt_o(key_evt[KEY_U])
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_d (
        .clkin(clkin), .rst_n(rst_n), .key_n_i(kd), .evt_o(key_evt[KEY_D])
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
        .clkin(clkin), .rst_n(rst_n), .key_n_i(kr), .evt_o(key_evt[KEY_R])
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_l (
        .clkin(clkin), .rst_n(rst_n), .key_n_i(kl), .evt_o(key_evt[KEY_L])
    );

    logic [DIGITS_W-1:0] digits_q, digits_d;
    logic [2:0]          cursor_q, cursor_d;
    logic                commit_req;
    logic [2:0]          cur_idx;
    logic [3:0]          cur_dig;
    logic [3:0]          cur_max;

    commit_st_e          state_q;
    logic [DIGITS_W-1:0] snap_q;
    logic [FREQ_W-1:0]   acc_q, acc_next;
    logic [2:0]          idx_q;
    logic                pending_q;
    logic [FREQ_W-1:0]   freq_word_q;
    logic                freq_valid_q;
    logic                busy_q;

    assign cur_idx = cursor_q - 3'd1;
    assign cur_dig = get_digit(digits_q, cur_idx);
    assign cur_max = DIGIT_MAX[cur_idx];

    // Apply only the highest-priority key event of the cycle.
    always_comb begin
        digits_d   = digits_q;
        cursor_d   = cursor_q;
        commit_req = 1'b0;
        if (key_evt[KEY_E]) begin
            commit_req = 1'b1;
        end else if (key_evt[KEY_U]) begin
            digits_d   = put_digit(digits_q, cur_idx, (cur_dig >= cur_max) ? 4'd0 : cur_dig + 4'd1);
            commit_req = 1'b1;
        end else if (key_evt[KEY_D]) begin
            digits_d   = put_digit(digits_q, cur_idx, (cur_dig == 4'd0) ? cur_max : cur_dig - 4'd1);
            commit_req = 1'b1;
        end else if (key_evt[KEY_R]) begin
            cursor_d = (cursor_q == 3'(NUM_DIGITS)) ? 3'd1 : cursor_q + 3'd1;
        end else if (key_evt[KEY_L]) begin
            cursor_d = (cursor_q == 3'd1) ? 3'(NUM_DIGITS) : cursor_q - 3'd1;
        end
    end

    // Setpoint and cursor registers.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            digits_q <= '0;
            cursor_q <= 3'd1;
        end else begin
            digits_q <= digits_d;
            cursor_q <= cursor_d;
        end
    end

    // acc*10 + digit, with the multiply as two shifts.
    assign acc_next = (acc_q << 3) + (acc_q << 1) + FREQ_W'(get_digit(snap_q, idx_q));

    // Commit FSM; snapshots take digits_d so a commit sees its own edit.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            snap_q       <= '0;
            acc_q        <= '0;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            freq_word_q  <= '0;
            freq_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            freq_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (commit_req) begin
                        snap_q  <= digits_d;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StConv;
                    end
                end
                StConv: begin
                    acc_q <= acc_next;
                    if (commit_req) begin
                        pending_q <= 1'b1;
                    end
                    if (idx_q == 3'(NUM_DIGITS - 1)) begin
                        freq_word_q  <= acc_next;
                        freq_valid_q <= 1'b1;
                        busy_q       <= pending_q | commit_req;
                        state_q      <= StDone;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                StDone: begin
                    // A request arriving in DONE itself is folded into the re-entry.
                    if (pending_q || commit_req) begin
                        pending_q <= 1'b0;
                        snap_q    <= digits_d;
                        acc_q     <= '0;
                        idx_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= StConv;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign digits     = digits_q;
    assign cursor     = cursor_q;
    assign freq_word  = freq_word_q;
    assign freq_valid = freq_valid_q;
    assign busy       = busy_q;

endmodule
